// File: rtl/register_file_2r1w_if.sv
// Bus bundle for register_file_2r1w: write port, two read ports, clear control.
interface register_file_2r1w_if #(
  parameter int B = 8,
  parameter int W = 2
);
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [B-1:0] w_data;
  logic         rd_en_a;
  logic [W-1:0] r_addr_a;
  logic [B-1:0] r_data_a;
  logic         rd_en_b;
  logic [W-1:0] r_addr_b;
  logic [B-1:0] r_data_b;
  logic         clr_req;
  logic         busy;

  modport master (
    output wr_en, w_addr, w_data,
    output rd_en_a, r_addr_a, rd_en_b, r_addr_b,
    output clr_req,
    input  r_data_a, r_data_b, busy
  );

  modport slave (
    input  wr_en, w_addr, w_data,
    input  rd_en_a, r_addr_a, rd_en_b, r_addr_b,
    input  clr_req,
    output r_data_a, r_data_b, busy
  );
endinterface

// File: rtl/register_file_2r1w.sv
// 2**W x B register bank: one write port, two registered read ports, clear sweep.
// Optional macro RF_BYPASS_EN selects write-first same-address reads (default read-first).
module register_file_2r1w #(
  parameter int B = 8,
  parameter int W = 2
) (
  input logic clk,
  input logic rst_n,
  register_file_2r1w_if.slave bus
);
  // state    | meaning
  // ST_IDLE  | normal operation, writes and reads serviced
  // ST_CLEAR | zero sweep, one entry per cycle; writes dropped, reads give 0
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam int DEPTH = 2 ** W;

  state_t       r_state;
  logic [W-1:0] r_cnt;
  logic         r_busy;
  logic [B-1:0] r_data_a;
  logic [B-1:0] r_data_b;
  logic [B-1:0] r_mem [DEPTH];

  logic         w_wr_we;
  logic         w_clr_we;
  logic [B-1:0] w_rd_a;
  logic [B-1:0] w_rd_b;

  assign w_wr_we  = (r_state == ST_IDLE) && bus.wr_en;
  assign w_clr_we = (r_state == ST_CLEAR);

`ifdef RF_BYPASS_EN
  assign w_rd_a = (w_wr_we && (bus.w_addr == bus.r_addr_a)) ? bus.w_data : r_mem[bus.r_addr_a];
  assign w_rd_b = (w_wr_we && (bus.w_addr == bus.r_addr_b)) ? bus.w_data : r_mem[bus.r_addr_b];
`else
  assign w_rd_a = r_mem[bus.r_addr_a];
  assign w_rd_b = r_mem[bus.r_addr_b];
`endif

  // Array has no reset; contents survive rst_n except entries already swept.
  always_ff @(posedge clk) begin
    if (w_clr_we)
      r_mem[r_cnt] <= '0;
    else if (w_wr_we)
      r_mem[bus.w_addr] <= bus.w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rd_en_a) r_data_a <= w_rd_a;
          if (bus.rd_en_b) r_data_b <= w_rd_b;
          if (bus.clr_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (bus.rd_en_a) r_data_a <= '0;
          if (bus.rd_en_b) r_data_b <= '0;
          r_cnt <= r_cnt + W'(1);
          if (&r_cnt) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r_data_a = r_data_a;
  assign bus.r_data_b = r_data_b;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: directed plan plus randomized traffic vs. an array model.
module tb_register_file_2r1w;
  localparam int B = 8;
  localparam int W = 2;
  localparam int DEPTH = 2 ** W;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_file_2r1w_if #(.B(B), .W(W)) bus ();
  register_file_2r1w #(.B(B), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;
  logic [B-1:0] ref_mem [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.w_addr = '0; bus.w_data = '0;
    bus.rd_en_a = 0; bus.r_addr_a = '0;
    bus.rd_en_b = 0; bus.r_addr_b = '0;
    bus.clr_req = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    n_checks++;
    if (bus.r_data_a !== 8'd0 || bus.r_data_b !== 8'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: a=%0d b=%0d busy=%0b expected 0 0 0", bus.r_data_a, bus.r_data_b, bus.busy);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_read();
    int addrs [5] = '{0, 1, 2, 3, 3};
    int vals  [5] = '{100, 110, 120, 130, 140};
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1; bus.w_addr = W'(addrs[i]); bus.w_data = B'(vals[i]);
      tick();
      ref_mem[addrs[i]] = B'(vals[i]);
    end
    bus.wr_en = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_en_a = 1; bus.r_addr_a = W'(i);
      tick();
      n_checks++;
      if (bus.r_data_a !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL write_read addr %0d: got %0d expected %0d", i, bus.r_data_a, ref_mem[i]);
      end
    end
    bus.rd_en_a = 0;
  endtask

  task automatic test_hold();
    logic [B-1:0] held;
    held = ref_mem[3];
    for (int i = 0; i < 3; i++) begin
      bus.rd_en_a = 0; bus.r_addr_a = W'(i);
      tick();
      n_checks++;
      if (bus.r_data_a !== held) begin
        n_fail++;
        $display("FAIL hold step %0d: got %0d expected %0d", i, bus.r_data_a, held);
      end
    end
  endtask

  task automatic test_dual_read();
    bus.wr_en = 1; bus.w_addr = 2; bus.w_data = 55;
    bus.rd_en_a = 1; bus.r_addr_a = 1;
    bus.rd_en_b = 1; bus.r_addr_b = 3;
    tick();
    ref_mem[2] = 55;
    n_checks++;
    if (bus.r_data_a !== 8'd110 || bus.r_data_b !== 8'd140) begin
      n_fail++;
      $display("FAIL dual_read: a=%0d b=%0d expected 110 140", bus.r_data_a, bus.r_data_b);
    end
    bus.wr_en = 0; bus.rd_en_b = 0; bus.r_addr_a = 2;
    tick();
    n_checks++;
    if (bus.r_data_a !== 8'd55) begin
      n_fail++;
      $display("FAIL dual_read_followup: got %0d expected 55", bus.r_data_a);
    end
    bus.rd_en_a = 0;
  endtask

  task automatic test_bypass();
    logic [B-1:0] exp_first;
    exp_first = BYPASS ? 8'd77 : ref_mem[0];
    bus.wr_en = 1; bus.w_addr = 0; bus.w_data = 77;
    bus.rd_en_b = 1; bus.r_addr_b = 0;
    tick();
    ref_mem[0] = 77;
    n_checks++;
    if (bus.r_data_b !== exp_first) begin
      n_fail++;
      $display("FAIL bypass_same_edge: got %0d expected %0d", bus.r_data_b, exp_first);
    end
    bus.wr_en = 0;
    tick();
    n_checks++;
    if (bus.r_data_b !== 8'd77) begin
      n_fail++;
      $display("FAIL bypass_next_read: got %0d expected 77", bus.r_data_b);
    end
    bus.rd_en_b = 0;
  endtask

  task automatic test_clear();
    int cnt;
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_busy_rise: got %0b expected 1", bus.busy);
    end
    bus.wr_en = 1; bus.w_addr = 3; bus.w_data = 99;
    bus.rd_en_a = 1; bus.r_addr_a = 2;
    bus.rd_en_b = 1; bus.r_addr_b = 3;
    cnt = 1;
    while (bus.busy === 1'b1 && cnt < 20) begin
      tick();
      bus.clr_req = 1;
      n_checks++;
      if (bus.r_data_a !== 8'd0 || bus.r_data_b !== 8'd0) begin
        n_fail++;
        $display("FAIL clear_read_busy: a=%0d b=%0d expected 0 0", bus.r_data_a, bus.r_data_b);
      end
      if (bus.busy === 1'b1) cnt++;
    end
    idle_inputs();
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_en_a = 1; bus.r_addr_a = W'(i);
      tick();
      n_checks++;
      if (bus.r_data_a !== 8'd0) begin
        n_fail++;
        $display("FAIL clear_after addr %0d: got %0d expected 0", i, bus.r_data_a);
      end
    end
    bus.rd_en_a = 0;
    if (bus.busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL clear_restart: busy=%0b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_during_clear();
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1; bus.w_addr = W'(i); bus.w_data = B'(i + 1);
      tick();
      ref_mem[i] = B'(i + 1);
    end
    bus.wr_en = 0;
    bus.rd_en_a = 1; bus.r_addr_a = 3;
    bus.rd_en_b = 1; bus.r_addr_b = 2;
    tick();
    bus.rd_en_a = 0; bus.rd_en_b = 0;
    n_checks++;
    if (bus.r_data_a !== 8'd4 || bus.r_data_b !== 8'd3) begin
      n_fail++;
      $display("FAIL rdc_preload: a=%0d b=%0d expected 4 3", bus.r_data_a, bus.r_data_b);
    end
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    tick();
    tick();
    ref_mem[0] = 0; ref_mem[1] = 0;
    rst_n = 0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.r_data_a !== 8'd0 || bus.r_data_b !== 8'd0) begin
      n_fail++;
      $display("FAIL rdc_async: busy=%0b a=%0d b=%0d expected 0 0 0", bus.busy, bus.r_data_a, bus.r_data_b);
    end
    #2;
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_en_a = 1; bus.r_addr_a = W'(i);
      bus.rd_en_b = 1; bus.r_addr_b = W'(i);
      tick();
      n_checks++;
      if (bus.r_data_a !== ref_mem[i] || bus.r_data_b !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL rdc_read addr %0d: a=%0d b=%0d expected %0d", i, bus.r_data_a, bus.r_data_b, ref_mem[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [B-1:0] exp_a, exp_b;
    exp_a = '0; exp_b = '0;
    for (int n = 0; n < 200; n++) begin
      bus.wr_en    = $urandom_range(0, 1);
      bus.w_addr   = W'($urandom_range(0, DEPTH - 1));
      bus.w_data   = B'($urandom);
      bus.rd_en_a  = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.rd_en_b  = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.r_addr_a = (n % 7 == 0) ? bus.w_addr : W'($urandom_range(0, DEPTH - 1));
      bus.r_addr_b = (n % 5 == 0) ? bus.w_addr : W'($urandom_range(0, DEPTH - 1));
      if (bus.rd_en_a)
        exp_a = (BYPASS && bus.wr_en && bus.w_addr == bus.r_addr_a) ? bus.w_data : ref_mem[bus.r_addr_a];
      if (bus.rd_en_b)
        exp_b = (BYPASS && bus.wr_en && bus.w_addr == bus.r_addr_b) ? bus.w_data : ref_mem[bus.r_addr_b];
      if (bus.wr_en) ref_mem[bus.w_addr] = bus.w_data;
      tick();
      n_checks++;
      if (bus.r_data_a !== exp_a || bus.r_data_b !== exp_b) begin
        n_fail++;
        $display("FAIL random cycle %0d: a=%0d b=%0d expected %0d %0d", n, bus.r_data_a, bus.r_data_b, exp_a, exp_b);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_dual_read();
    test_bypass();
    test_clear();
    test_reset_during_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised successor to the single-port register file.
- One synchronous write port and two independent registered read ports (A, B); reads and writes may occur in the same cycle.
- Built-in clear sequencer zeroes the whole array on request, one entry per cycle.
- Intended as the operand register bank for the datapath blocks; B/W scale it from 4x8 up to wide/deep configurations.

Parameters:
- B, 8, word size in bits (>=1).
- W, 2, address bits; depth = 2**W entries (W>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write enable
- w_addr  input  W  write address
- w_data  input  B  write data
- rd_en_a  input  1  read enable, port A
- r_addr_a  input  W  read address, port A
- r_data_a  output  B  registered read data, port A
- rd_en_b  input  1  read enable, port B
- r_addr_b  input  W  read address, port B
- r_data_b  output  B  registered read data, port B
- clr_req  input  1  single-cycle pulse: start array clear
- busy  output  1  high while clear sweep in progress

Behaviour:
- Reset (rst_n low, async): r_data_a=0, r_data_b=0, busy=0, FSM=IDLE, sweep counter=0. Array contents are not reset.
- Write: in IDLE, wr_en=1 at a rising edge stores w_data into RAM[w_addr]. Write visible to a read issued on the next edge.
- Read: rd_en_x=1 at a rising edge loads r_data_x <= RAM[r_addr_x]. Latency is 1 cycle. rd_en_x=0 holds r_data_x.
- Ports A and B are fully independent; both may read the same address in one cycle.
- Read-during-write, same address, same edge: behaviour is selected by RF_BYPASS_EN (see below). Different addresses: no interaction.
- FSM IDLE: clr_req=1 at an edge moves to CLEAR, busy=1 from that edge, counter=0.
- FSM CLEAR: each edge writes RAM[counter]=0 and increments counter. On the edge clearing address 2**W-1, FSM returns to IDLE and busy=0. Total is 2**W cycles of busy.
- During CLEAR:
  - wr_en is ignored and its data is dropped.
  - Reads with rd_en_x=1 load r_data_x=0.
  - clr_req is ignored and does not restart the sweep.
- clr_req and wr_en in the same IDLE cycle: the write is performed first, then the clear starts. The written entry ends as 0.
- Counter is W bits and wraps naturally; no out-of-range addresses exist.
- Reset during CLEAR: immediate return to IDLE, busy=0. Already-cleared entries stay 0; the rest keep their old contents.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: write-first. A same-edge read of w_addr while wr_en=1 (IDLE) returns w_data.
- Undefined: read-first. The read returns the previous RAM contents; the new data is seen on the next read.

Test Plan:
- Reset then write 0:100, 1:110, 2:120, 3:130, 3:140; read A at 0..3 on consecutive edges -> r_data_a = 100, 110, 120, 140, each one cycle after its address.
- Same cycle: write 2:55, read A addr 1, read B addr 3 -> next cycle r_data_a=110, r_data_b=140; a subsequent read of addr 2 gives 55.
- Same-edge write 0:77 with read B addr 0 -> r_data_b=77 with RF_BYPASS_EN defined, 100 without it; the following read gives 77 in both builds.
- Pulse clr_req -> busy high for exactly 4 cycles. A wr_en 3:99 issued during busy is dropped. Reads during busy give 0. After busy falls, reads of 0..3 all give 0.
- Fill with 1,2,3,4, pulse clr_req, drop rst_n after 2 busy cycles -> busy=0 and r_data_a/b=0 immediately; reads return 0, 0, 3, 4.
- rd_en_a=0 with r_addr_a changing -> r_data_a holds its last value.
